qm_decode_stage: RTL and testbench
==================================

// Module: qm_decode_stage
// PURPOSE
//  Pipelined ID stage of the qm MIPS core: holds a parametrised register file, decodes the IR
//  and registers operands plus control into the ID/EX pipeline register. Detects load-use
//  hazards and stalls fetch. Honours downstream hold and branch flush.
//  Sits between qm_fetch and qm_execute; the control unit decodes o_Opcode/o_Function.
// PARAMETERS
//  DATA_W  32  register/operand width, 32 or 64; immediate sign-extended to DATA_W
//  NREGS   32  architectural registers, 16 or 32; index = low clog2(NREGS) bits of IR field
//  ALUC_W  4   width of ALU control field
// PORTS
//  clk            in   1       core clock, all state on rising edge
//  reset_n        in   1       asynchronous active-low reset
//  di_Valid       in   1       di_IR/di_PC hold a valid instruction
//  di_IR          in   32      instruction from fetch
//  di_PC          in   32      PC of di_IR
//  di_WA          in   5       writeback register address
//  di_WE          in   1       writeback enable
//  di_WD          in   DATA_W  writeback data
//  i_Hold         in   1       downstream stall: freeze ID/EX register
//  i_Flush        in   1       branch taken: kill instruction entering ID/EX
//  o_Opcode       out  6       di_IR[31:26], combinational
//  o_Function     out  6       di_IR[5:0], combinational
//  o_Stall        out  1       fetch must hold di_IR/di_PC this cycle
//  ci_RegWrite, ci_RegWSource, ci_MemWrite, ci_ALUSource, ci_RegDest, ci_Branch  in 1 each
//  ci_ALUControl  in   ALUC_W  control from control unit (combinational on o_Opcode/o_Function)
//  co_*           out  as ci_*  registered control (co_Branch included)
//  do_Valid       out  1       ID/EX slot holds a live instruction
//  do_RSVal, do_RTVal  out DATA_W  registered operand values
//  do_Imm         out  DATA_W  registered sign-extended di_IR[15:0]
//  do_RS, do_RT, do_RD  out 5  registered di_IR[25:21], [20:16], [15:11]
//  do_PC          out  32      registered di_PC
// BEHAVIOUR
//  - Reset (async, reset_n=0): all do_*/co_* = 0, do_Valid=0, all registers = 0.
//  - Register file: write on rising edge when di_WE && di_WA!=0; reg 0 always reads 0.
//    Writes occur regardless of i_Hold/i_Flush/hazard.
//  - Reads combinational from rs/rt index; latency ID->do_* = 1 cycle.
//  - Load-use hazard: haz = do_Valid && co_RegWrite && co_RegWSource && do_RT!=0 &&
//    di_Valid && (do_RT==rs || do_RT==rt).
//  - o_Stall = i_Hold || haz.
//  - ID/EX update priority per edge:
//    1. i_Flush: do_Valid<=0, co_RegWrite/co_MemWrite/co_Branch<=0. Flush overrides i_Hold.
//    2. i_Hold: every ID/EX field holds its value.
//    3. haz: insert bubble (do_Valid<=0, co_RegWrite/co_MemWrite/co_Branch<=0); IR held by fetch.
//    4. else capture all fields; do_Valid<=di_Valid. Write-enables are gated to 0 when !di_Valid.
//  - When do_Valid=0, co_RegWrite/co_MemWrite/co_Branch are guaranteed 0.
//  - Remaining bubble fields are don't-care.
//  - Hazard clears the following cycle, since the bubble drops do_Valid: a stall lasts exactly 1 cycle.
// CONFIGURATION
//  QM_DECODE_BYPASS_EN defined: a same-cycle writeback to rs/rt (di_WE, di_WA==index, !=0)
//    forwards di_WD into the captured do_RSVal/do_RTVal (write-before-read).
//  Undefined: reads return the pre-write array value. The writeback result is visible
//    to decode one cycle later, and software/hazard logic upstream must cover the gap.
// TESTING
//  1. reset_n=0 mid-run, no clk edge -> do_Valid=0, do_RSVal=0, co_RegWrite=0 immediately.
//  2. Write r5=0x1234 via di_WE; next cycle decode addu $3,$5,$0 -> do_RSVal=0x1234,
//     do_RTVal=0, do_RD=3, do_Valid=1.
//  3. di_WA=0, di_WE=1, di_WD=0xFFFF; then read r0 -> do_RSVal=0.
//  4. lw $8,0($1) in ID/EX, then addu $2,$8,$9 in ID -> o_Stall=1 for 1 cycle, bubble
//     (do_Valid=0, co_RegWrite=0), then addu captured with do_RS=8.
//  5. i_Hold=1 and i_Flush=1 together -> do_Valid=0 next edge.
//     i_Hold alone for 3 cycles -> do_* unchanged, o_Stall=1.
//  6. Same-cycle write r7=0xCAFE with read of r7 -> do_RSVal=0xCAFE if QM_DECODE_BYPASS_EN,
//     else old r7 value. Sign-extend imm 0x8000 -> do_Imm=0xFFFF8000 (DATA_W=32).

Source files
------------

// File: rtl/qm_decode_stage.sv
// qm ID stage: register file, operand/immediate decode and the ID/EX pipeline register.
// Latency: operands and control appear on do_*/co_* one cycle after the instruction is presented.
// Backpressure: i_Hold freezes ID/EX; a load-use hazard or i_Hold raises o_Stall so fetch holds the IR.
// Optional feature: define QM_DECODE_BYPASS_EN to forward a same-cycle writeback into captured operands.
module qm_decode_stage #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int ALUC_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              di_Valid,
    input  logic [31:0]       di_IR,
    input  logic [31:0]       di_PC,
    input  logic [4:0]        di_WA,
    input  logic              di_WE,
    input  logic [DATA_W-1:0] di_WD,
    input  logic              i_Hold,
    input  logic              i_Flush,
    output logic [5:0]        o_Opcode,
    output logic [5:0]        o_Function,
    output logic              o_Stall,
    input  logic              ci_RegWrite,
    input  logic              ci_RegWSource,
    input  logic              ci_MemWrite,
    input  logic              ci_ALUSource,
    input  logic              ci_RegDest,
    input  logic              ci_Branch,
    input  logic [ALUC_W-1:0] ci_ALUControl,
    output logic              co_RegWrite,
    output logic              co_RegWSource,
    output logic              co_MemWrite,
    output logic              co_ALUSource,
    output logic              co_RegDest,
    output logic              co_Branch,
    output logic [ALUC_W-1:0] co_ALUControl,
    output logic              do_Valid,
    output logic [DATA_W-1:0] do_RSVal,
    output logic [DATA_W-1:0] do_RTVal,
    output logic [DATA_W-1:0] do_Imm,
    output logic [4:0]        do_RS,
    output logic [4:0]        do_RT,
    output logic [4:0]        do_RD,
    output logic [31:0]       do_PC
);
    localparam int IDX_W = $clog2(NREGS);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              reg_wsource;
        logic              mem_write;
        logic              alu_source;
        logic              reg_dest;
        logic              branch;
        logic [ALUC_W-1:0] alu_ctrl;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [31:0]       pc;
    } idex_t;

    logic [DATA_W-1:0] regs_q [NREGS];
    idex_t             idex_q;
    idex_t             idex_d;

    logic [IDX_W-1:0]  rs_idx;
    logic [IDX_W-1:0]  rt_idx;
    logic [IDX_W-1:0]  wa_idx;
    logic              wr_en;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              haz;
    logic              unused_ok;

    assign rs_idx = di_IR[21 +: IDX_W];
    assign rt_idx = di_IR[16 +: IDX_W];
    assign wa_idx = di_WA[IDX_W-1:0];
    // Compare the truncated index so a write can never land in r0 when NREGS=16.
    assign wr_en  = di_WE && (wa_idx != '0);

    assign o_Opcode   = di_IR[31:26];
    assign o_Function = di_IR[5:0];

    // Shamt and any index bits above IDX_W are not needed by this stage.
    assign unused_ok = ^{di_IR[10:6], di_WA};

    // Operand read; r0 is never written so it always reads zero.
    always_comb begin
        rs_val = regs_q[rs_idx];
        rt_val = regs_q[rt_idx];
`ifdef QM_DECODE_BYPASS_EN
        if (wr_en && (wa_idx == rs_idx)) rs_val = di_WD;
        if (wr_en && (wa_idx == rt_idx)) rt_val = di_WD;
`endif
    end

    // A load sitting in ID/EX whose target is read by the instruction now in ID.
    assign haz = idex_q.valid && idex_q.reg_write && idex_q.reg_wsource &&
                 (idex_q.rt != 5'd0) && di_Valid &&
                 ((idex_q.rt == di_IR[25:21]) || (idex_q.rt == di_IR[20:16]));

    assign o_Stall = i_Hold || haz;

    // Register file write port; independent of hold, flush and hazard.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[wa_idx] <= di_WD;
        end
    end

    // ID/EX next state: flush beats hold, hold beats bubble, else capture.
    always_comb begin
        idex_d = idex_q;
        if (i_Flush || (!i_Hold && haz)) begin
            idex_d.valid     = 1'b0;
            idex_d.reg_write = 1'b0;
            idex_d.mem_write = 1'b0;
            idex_d.branch    = 1'b0;
        end else if (!i_Hold) begin
            idex_d.valid       = di_Valid;
            idex_d.reg_write   = ci_RegWrite && di_Valid;
            idex_d.reg_wsource = ci_RegWSource;
            idex_d.mem_write   = ci_MemWrite && di_Valid;
            idex_d.alu_source  = ci_ALUSource;
            idex_d.reg_dest    = ci_RegDest;
            idex_d.branch      = ci_Branch && di_Valid;
            idex_d.alu_ctrl    = ci_ALUControl;
            idex_d.rs_val      = rs_val;
            idex_d.rt_val      = rt_val;
            idex_d.imm         = {{(DATA_W-16){di_IR[15]}}, di_IR[15:0]};
            idex_d.rs          = di_IR[25:21];
            idex_d.rt          = di_IR[20:16];
            idex_d.rd          = di_IR[15:11];
            idex_d.pc          = di_PC;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) idex_q <= '0;
        else          idex_q <= idex_d;
    end

    assign do_Valid      = idex_q.valid;
    assign co_RegWrite   = idex_q.reg_write;
    assign co_RegWSource = idex_q.reg_wsource;
    assign co_MemWrite   = idex_q.mem_write;
    assign co_ALUSource  = idex_q.alu_source;
    assign co_RegDest    = idex_q.reg_dest;
    assign co_Branch     = idex_q.branch;
    assign co_ALUControl = idex_q.alu_ctrl;
    assign do_RSVal      = idex_q.rs_val;
    assign do_RTVal      = idex_q.rt_val;
    assign do_Imm        = idex_q.imm;
    assign do_RS         = idex_q.rs;
    assign do_RT         = idex_q.rt;
    assign do_RD         = idex_q.rd;
    assign do_PC         = idex_q.pc;
endmodule

// File: tb/tb_qm_decode_stage.sv
// Directed bench for qm_decode_stage (DATA_W=32, NREGS=32).
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Hazard/hold/flush sequences and register-file corner cases with hand-computed expectations.
module tb_qm_decode_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        di_Valid;
    logic [31:0] di_IR;
    logic [31:0] di_PC;
    logic [4:0]  di_WA;
    logic        di_WE;
    logic [31:0] di_WD;
    logic        i_Hold;
    logic        i_Flush;
    logic [5:0]  o_Opcode;
    logic [5:0]  o_Function;
    logic        o_Stall;
    logic        ci_RegWrite, ci_RegWSource, ci_MemWrite, ci_ALUSource, ci_RegDest, ci_Branch;
    logic [3:0]  ci_ALUControl;
    logic        co_RegWrite, co_RegWSource, co_MemWrite, co_ALUSource, co_RegDest, co_Branch;
    logic [3:0]  co_ALUControl;
    logic        do_Valid;
    logic [31:0] do_RSVal, do_RTVal, do_Imm;
    logic [4:0]  do_RS, do_RT, do_RD;
    logic [31:0] do_PC;

    int passed = 0;
    int total  = 0;

    qm_decode_stage #(.DATA_W(32), .NREGS(32), .ALUC_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .di_Valid(di_Valid), .di_IR(di_IR), .di_PC(di_PC),
        .di_WA(di_WA), .di_WE(di_WE), .di_WD(di_WD),
        .i_Hold(i_Hold), .i_Flush(i_Flush),
        .o_Opcode(o_Opcode), .o_Function(o_Function), .o_Stall(o_Stall),
        .ci_RegWrite(ci_RegWrite), .ci_RegWSource(ci_RegWSource), .ci_MemWrite(ci_MemWrite),
        .ci_ALUSource(ci_ALUSource), .ci_RegDest(ci_RegDest), .ci_Branch(ci_Branch),
        .ci_ALUControl(ci_ALUControl),
        .co_RegWrite(co_RegWrite), .co_RegWSource(co_RegWSource), .co_MemWrite(co_MemWrite),
        .co_ALUSource(co_ALUSource), .co_RegDest(co_RegDest), .co_Branch(co_Branch),
        .co_ALUControl(co_ALUControl),
        .do_Valid(do_Valid), .do_RSVal(do_RSVal), .do_RTVal(do_RTVal), .do_Imm(do_Imm),
        .do_RS(do_RS), .do_RT(do_RT), .do_RD(do_RD), .do_PC(do_PC)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic rw, input logic ws, input logic mw, input logic as,
                           input logic rd, input logic br, input logic [3:0] ac);
        ci_RegWrite = rw; ci_RegWSource = ws; ci_MemWrite = mw;
        ci_ALUSource = as; ci_RegDest = rd; ci_Branch = br; ci_ALUControl = ac;
    endtask

    logic [31:0] exp_r7;

    initial begin
        reset_n = 1'b0; di_Valid = 1'b0; di_IR = '0; di_PC = '0;
        di_WA = '0; di_WE = 1'b0; di_WD = '0; i_Hold = 1'b0; i_Flush = 1'b0;
        set_ctl(0, 0, 0, 0, 0, 0, 4'h0);
        #2;
        chk("reset_valid", do_Valid, 1'b0);
        chk("reset_rsval", do_RSVal, 32'h0);
        #10 reset_n = 1'b1;
        step();

        // Write r5 = 0x1234 with no instruction in ID.
        di_WE = 1'b1; di_WA = 5'd5; di_WD = 32'h1234;
        step();
        // addu $3,$5,$0
        di_WE = 1'b0; di_Valid = 1'b1; di_IR = 32'h00A01821; di_PC = 32'h100;
        set_ctl(1, 0, 0, 0, 1, 0, 4'h2);
        #1;
        chk("opcode_r", o_Opcode, 6'h00);
        chk("function_addu", o_Function, 6'h21);
        step();
        chk("addu_rsval", do_RSVal, 32'h1234);
        chk("addu_rtval", do_RTVal, 32'h0);
        chk("addu_rd", do_RD, 5'd3);
        chk("addu_valid", do_Valid, 1'b1);
        chk("addu_regwrite", co_RegWrite, 1'b1);
        chk("addu_pc", do_PC, 32'h100);
        chk("addu_aluctl", co_ALUControl, 4'h2);

        // Attempted write to r0 with an invalid slot: write-enables gated.
        di_Valid = 1'b0; di_WE = 1'b1; di_WA = 5'd0; di_WD = 32'hFFFF;
        step();
        chk("invalid_valid", do_Valid, 1'b0);
        chk("invalid_regwrite_gated", co_RegWrite, 1'b0);
        // addu $4,$0,$5
        di_WE = 1'b0; di_Valid = 1'b1; di_IR = 32'h00052021; di_PC = 32'h104;
        step();
        chk("r0_reads_zero", do_RSVal, 32'h0);
        chk("r5_rtval", do_RTVal, 32'h1234);

        // lw $8,0($1) then addu $2,$8,$9 -> one-cycle load-use stall.
        di_IR = 32'h8C280000; di_PC = 32'h108;
        set_ctl(1, 1, 0, 1, 0, 0, 4'h2);
        step();
        chk("lw_rt", do_RT, 5'd8);
        chk("lw_wsource", co_RegWSource, 1'b1);
        di_IR = 32'h01091021; di_PC = 32'h10C;
        set_ctl(1, 0, 0, 0, 1, 0, 4'h2);
        #1;
        chk("loaduse_stall", o_Stall, 1'b1);
        step();
        chk("bubble_valid", do_Valid, 1'b0);
        chk("bubble_regwrite", co_RegWrite, 1'b0);
        chk("stall_cleared", o_Stall, 1'b0);
        step();
        chk("after_bubble_valid", do_Valid, 1'b1);
        chk("after_bubble_rs", do_RS, 5'd8);
        chk("after_bubble_rd", do_RD, 5'd2);
        chk("after_bubble_pc", do_PC, 32'h10C);

        // Hold alone for three cycles: ID/EX frozen while ID input changes.
        i_Hold = 1'b1; di_IR = 32'h00A01821; di_PC = 32'h110;
        #1;
        chk("hold_stall", o_Stall, 1'b1);
        for (int i = 0; i < 3; i++) step();
        chk("hold_rs", do_RS, 5'd8);
        chk("hold_pc", do_PC, 32'h10C);
        chk("hold_valid", do_Valid, 1'b1);
        chk("hold_stall_still", o_Stall, 1'b1);
        // Flush overrides hold.
        i_Flush = 1'b1;
        step();
        chk("flush_valid", do_Valid, 1'b0);
        chk("flush_regwrite", co_RegWrite, 1'b0);
        i_Hold = 1'b0; i_Flush = 1'b0;

        // addiu $10,$7,0x8000 with same-cycle write r7=0xCAFE.
        di_IR = 32'h24EA8000; di_PC = 32'h114;
        di_WE = 1'b1; di_WA = 5'd7; di_WD = 32'hCAFE;
        set_ctl(1, 0, 0, 1, 0, 0, 4'h2);
`ifdef QM_DECODE_BYPASS_EN
        exp_r7 = 32'hCAFE;
`else
        exp_r7 = 32'h0;
`endif
        step();
        chk("same_cycle_rsval", do_RSVal, {32'h0, exp_r7});
        chk("imm_sext", do_Imm, 32'hFFFF8000);
        chk("addiu_rt", do_RT, 5'd10);
        // Re-decode: now captured as a load into r10, write visible.
        di_WE = 1'b0;
        set_ctl(1, 1, 0, 1, 0, 0, 4'h2);
        step();
        chk("r7_after_write", do_RSVal, 32'hCAFE);
        // Independent instruction: addu $2,$3,$4 -> no stall.
        di_IR = 32'h00641021;
        set_ctl(1, 0, 0, 0, 1, 0, 4'h2);
        #1;
        chk("no_dep_no_stall", o_Stall, 1'b0);
        // Dependent: addu $2,$10,$4 -> stall.
        di_IR = 32'h01441021;
        #1;
        chk("dep_r10_stall", o_Stall, 1'b1);
        // Invalid ID slot never stalls.
        di_Valid = 1'b0;
        #1;
        chk("invalid_no_stall", o_Stall, 1'b0);

        // Asynchronous reset mid-run, away from any clock edge.
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_valid", do_Valid, 1'b0);
        chk("async_reset_rsval", do_RSVal, 32'h0);
        chk("async_reset_regwrite", co_RegWrite, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
